// File: rtl/clk_seq_pkg.sv
// Shared types and constants for the clock phase sequencer: control FSM states,
// the reset-settle length, and the per-channel phase lookup.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3,
    STEP   = 3'd4
  } state_t;

  // Board-clock cycles spent in HOLD after reset so the memories can settle.
  localparam int HOLD_CYC = 2;
  localparam int HOLD_W   = 2;

  // Widest phase vector the lookup accepts; narrower vectors are zero-extended.
  localparam int MAX_NCH = 32;
  localparam int PV_W    = 8 * MAX_NCH;

  function automatic logic [7:0] phase_field(input logic [PV_W-1:0] vec, input int idx);
    return vec[8*idx +: 8];
  endfunction

endpackage

// File: rtl/clk_seq_phase_dec.sv
// Phase decoder: maps a phase value onto the per-channel enable vector.
// Purely combinational; the caller registers the result.
module clk_seq_phase_dec
  import clk_seq_pkg::*;
#(
  parameter int                 DIV       = 4,
  parameter int                 NCH       = 4,
  parameter int                 CW        = $clog2(DIV),
  parameter logic [8*NCH-1:0]   PHASE_VEC = {8'd3, 8'd2, 8'd1, 8'd0}
)(
  input  logic [CW-1:0]  i_phase,
  output logic [NCH-1:0] o_en
);

  localparam logic [PV_W-1:0] PV_EXT = PV_W'(PHASE_VEC);

  always_comb begin
    o_en = '0;
    for (int i = 0; i < NCH; i++) begin
      o_en[i] = (int'(i_phase) == int'(phase_field(PV_EXT, i)));
    end
  end

endmodule

// File: rtl/clk_phase_sequencer.sv
// Board-clock divider with per-domain phase enables and a run/halt/step control FSM.
// Optional performance counter of completed periods: define CLKSEQ_PERF_CNT_EN.
module clk_phase_sequencer
  import clk_seq_pkg::*;
#(
  parameter int               DIV       = 4,
  parameter int               NCH       = 4,
  parameter int               CW        = $clog2(DIV),
  parameter logic [8*NCH-1:0] PHASE_VEC = {8'd3, 8'd2, 8'd1, 8'd0},
  parameter int               CNT_W     = 32
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             cnt_clr,
  output logic             clk_out,
  output logic [NCH-1:0]   en,
  output logic [CW-1:0]    phase,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output state_t           o_state
);

  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("clk_phase_sequencer: DIV must be even and >= 2");
  end
  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("clk_phase_sequencer: NCH out of range");
  end
  for (genvar g = 0; g < NCH; g++) begin : g_pv_chk
    if (int'(PHASE_VEC[8*g +: 8]) >= DIV) begin : g_bad_phase
      $error("clk_phase_sequencer: PHASE_VEC entry must be < DIV");
    end
  end

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [CW-1:0]       r_phase;
  logic                r_clk_out;
  logic [NCH-1:0]      r_en;
  logic                r_halted;
  logic                r_step_done;

  logic                w_counting;
  logic                w_wrap;
  logic [CW-1:0]       w_cand_phase;
  logic                w_cand_clk;
  logic [NCH-1:0]      w_cand_en;

  // Candidate outputs assume the next cycle is a counting one: entering from an
  // idle state starts the period at phase 0; otherwise the phase advances.
  always_comb begin
    w_counting = (r_state == RUN) || (r_state == DRAIN) || (r_state == STEP);
    w_wrap     = (r_phase == CW'(DIV - 1));
    if (!w_counting || w_wrap) begin
      w_cand_phase = '0;
    end else begin
      w_cand_phase = r_phase + CW'(1);
    end
    w_cand_clk = (int'(w_cand_phase) < (DIV / 2));
  end

  clk_seq_phase_dec #(
    .DIV       (DIV),
    .NCH       (NCH),
    .CW        (CW),
    .PHASE_VEC (PHASE_VEC)
  ) u_phase_dec (
    .i_phase (w_cand_phase),
    .o_en    (w_cand_en)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= HOLD;
      r_hold_cnt  <= '0;
      r_phase     <= '0;
      r_clk_out   <= 1'b0;
      r_en        <= '0;
      r_halted    <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_phase     <= w_cand_phase;
      r_clk_out   <= w_cand_clk;
      r_en        <= w_cand_en;
      r_halted    <= 1'b0;
      r_step_done <= 1'b0;
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
            r_state <= RUN;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            r_phase    <= '0;
            r_clk_out  <= 1'b0;
            r_en       <= '0;
          end
        end
        RUN: begin
          // A request landing on the last phase halts at this very boundary.
          if (halt_req) begin
            if (w_wrap) begin
              r_state   <= HALTED;
              r_halted  <= 1'b1;
              r_phase   <= '0;
              r_clk_out <= 1'b0;
              r_en      <= '0;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_wrap) begin
            if (halt_req) begin
              r_state   <= HALTED;
              r_halted  <= 1'b1;
              r_phase   <= '0;
              r_clk_out <= 1'b0;
              r_en      <= '0;
            end else begin
              r_state <= RUN;
            end
          end
        end
        HALTED: begin
          if (!halt_req) begin
            r_state <= RUN;
          end else if (step_req) begin
            r_state <= STEP;
          end else begin
            r_halted  <= 1'b1;
            r_phase   <= '0;
            r_clk_out <= 1'b0;
            r_en      <= '0;
          end
        end
        STEP: begin
          if (w_wrap) begin
            r_state     <= HALTED;
            r_halted    <= 1'b1;
            r_step_done <= 1'b1;
            r_phase     <= '0;
            r_clk_out   <= 1'b0;
            r_en        <= '0;
          end
        end
        default: begin
          r_state   <= HOLD;
          r_phase   <= '0;
          r_clk_out <= 1'b0;
          r_en      <= '0;
        end
      endcase
    end
  end

`ifdef CLKSEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Saturating count of completed periods; a clear beats a same-cycle wrap.
  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      r_cycle_cnt <= '0;
    end else if (w_counting && w_wrap && (r_cycle_cnt != '1)) begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign cycle_cnt        = '0;
`endif

  assign clk_out   = r_clk_out;
  assign en        = r_en;
  assign phase     = r_phase;
  assign halted    = r_halted;
  assign step_done = r_step_done;
  assign o_state   = r_state;

endmodule

// File: tb/tb_clk_phase_sequencer.sv
// Bench for clk_phase_sequencer: two instances (DIV=4/NCH=4/CNT_W=4 and DIV=6/NCH=2)
// checked every cycle against a period-level reference model, plus directed latency checks.
module tb_clk_phase_sequencer;
  import clk_seq_pkg::*;

  localparam logic [31:0] A_PV = {8'd3, 8'd2, 8'd1, 8'd0};
  localparam logic [15:0] B_PV = {8'd4, 8'd1};

  int checks = 0;
  int errors = 0;

  logic clock;
  logic rst [2];
  logic hreq[2];
  logic sreq[2];
  logic clr [2];

  logic        a_clk_out, a_halted, a_step_done;
  logic [3:0]  a_en;
  logic [1:0]  a_phase;
  logic [3:0]  a_cnt;
  state_t      a_state;

  logic        b_clk_out, b_halted, b_step_done;
  logic [1:0]  b_en;
  logic [2:0]  b_phase;
  logic [31:0] b_cnt;
  state_t      b_state;

  clk_phase_sequencer #(.DIV(4), .NCH(4), .PHASE_VEC(A_PV), .CNT_W(4)) dut_a (
    .clock(clock), .reset(rst[0]), .halt_req(hreq[0]), .step_req(sreq[0]), .cnt_clr(clr[0]),
    .clk_out(a_clk_out), .en(a_en), .phase(a_phase), .halted(a_halted),
    .step_done(a_step_done), .cycle_cnt(a_cnt), .o_state(a_state)
  );

  clk_phase_sequencer #(.DIV(6), .NCH(2), .PHASE_VEC(B_PV), .CNT_W(32)) dut_b (
    .clock(clock), .reset(rst[1]), .halt_req(hreq[1]), .step_req(sreq[1]), .cnt_clr(clr[1]),
    .clk_out(b_clk_out), .en(b_en), .phase(b_phase), .halted(b_halted),
    .step_done(b_step_done), .cycle_cnt(b_cnt), .o_state(b_state)
  );

  // Clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // Reference model: position within the current period (-1 when frozen or settling).
  typedef struct {
    int          div;
    int          nch;
    logic [31:0] pv;
    int          pos;
    int          hold_left;
    bit          frozen;
    bit          stepping;
    bit          step_done;
    longint      cnt;
    longint      cnt_max;
  } model_t;

  model_t m[2];

  function automatic model_t model_init(int div, int nch, logic [31:0] pv, int cnt_w);
    model_t x;
    x.div       = div;
    x.nch       = nch;
    x.pv        = pv;
    x.pos       = -1;
    x.hold_left = HOLD_CYC;
    x.frozen    = 1'b0;
    x.stepping  = 1'b0;
    x.step_done = 1'b0;
    x.cnt       = 0;
    x.cnt_max   = (longint'(1) << cnt_w) - 1;
    return x;
  endfunction

  function automatic model_t model_next(model_t x, bit r, bit h, bit s, bit c);
    model_t n;
    bit     wrap;
    n           = x;
    n.step_done = 1'b0;
    if (r) begin
      n.pos       = -1;
      n.hold_left = HOLD_CYC;
      n.frozen    = 1'b0;
      n.stepping  = 1'b0;
      n.cnt       = 0;
      return n;
    end
    wrap = (x.pos == x.div - 1);
    if (c) n.cnt = 0;
    else if (wrap && n.cnt < n.cnt_max) n.cnt = n.cnt + 1;
    if (x.hold_left > 0) begin
      n.hold_left = x.hold_left - 1;
      if (n.hold_left == 0) n.pos = 0;
    end else if (x.frozen) begin
      if (!h) begin
        n.frozen = 1'b0;
        n.pos    = 0;
      end else if (s) begin
        n.frozen   = 1'b0;
        n.stepping = 1'b1;
        n.pos      = 0;
      end
    end else if (x.stepping) begin
      if (wrap) begin
        n.stepping  = 1'b0;
        n.frozen    = 1'b1;
        n.step_done = 1'b1;
        n.pos       = -1;
      end else begin
        n.pos = x.pos + 1;
      end
    end else begin
      // Running: a halt takes effect only at the period boundary.
      if (wrap) begin
        if (h) begin
          n.frozen = 1'b1;
          n.pos    = -1;
        end else begin
          n.pos = 0;
        end
      end else begin
        n.pos = x.pos + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] exp_en(model_t x);
    logic [63:0] e;
    e = '0;
    if (x.pos >= 0) begin
      for (int i = 0; i < x.nch; i++) begin
        if (x.pos == int'(x.pv[8*i +: 8])) e[i] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [63:0] obs_phase(int sel);
    return (sel == 0) ? 64'(a_phase) : 64'(b_phase);
  endfunction

  function automatic logic obs_halted(int sel);
    return (sel == 0) ? a_halted : b_halted;
  endfunction

  function automatic logic obs_clk(int sel);
    return (sel == 0) ? a_clk_out : b_clk_out;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int sel);
    model_t      x;
    logic [63:0] o_en, o_hal, o_sd, o_cnt, o_clk, e_cnt;
    state_t      st;
    x     = m[sel];
    o_clk = (sel == 0) ? 64'(a_clk_out) : 64'(b_clk_out);
    o_en  = (sel == 0) ? 64'(a_en) : 64'(b_en);
    o_hal = (sel == 0) ? 64'(a_halted) : 64'(b_halted);
    o_sd  = (sel == 0) ? 64'(a_step_done) : 64'(b_step_done);
    o_cnt = (sel == 0) ? 64'(a_cnt) : 64'(b_cnt);
    st    = (sel == 0) ? a_state : b_state;
`ifdef CLKSEQ_PERF_CNT_EN
    e_cnt = 64'(x.cnt);
`else
    e_cnt = '0;
`endif
    check($sformatf("d%0d phase", sel), obs_phase(sel), 64'((x.pos >= 0) ? x.pos : 0));
    check($sformatf("d%0d clk_out", sel), o_clk, 64'((x.pos >= 0) && (x.pos < x.div / 2)));
    check($sformatf("d%0d en", sel), o_en, exp_en(x));
    check($sformatf("d%0d halted", sel), o_hal, 64'(x.frozen));
    check($sformatf("d%0d step_done", sel), o_sd, 64'(x.step_done));
    check($sformatf("d%0d cycle_cnt", sel), o_cnt, e_cnt);
    if (x.hold_left > 0) check($sformatf("d%0d state_hold", sel), 64'(st), 64'(HOLD));
    else if (x.frozen) check($sformatf("d%0d state_halted", sel), 64'(st), 64'(HALTED));
    else if (x.stepping) check($sformatf("d%0d state_step", sel), 64'(st), 64'(STEP));
    else check($sformatf("d%0d state_run", sel), 64'((st == RUN) || (st == DRAIN)), 64'(1));
  endtask

  // Driver tasks
  task automatic cycle();
    @(posedge clock);
    for (int s = 0; s < 2; s++) m[s] = model_next(m[s], rst[s], hreq[s], sreq[s], clr[s]);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic wait_pos(input int sel, input int p, input int budget);
    int n;
    n = 0;
    while (m[sel].pos != p && n < budget) begin
      cycle();
      n++;
    end
    check($sformatf("d%0d wait_phase", sel), obs_phase(sel), 64'(p));
  endtask

  task automatic reset_mid_step(input int sel);
    int n;
    hreq[sel] = 1'b1;
    n = 0;
    while (!obs_halted(sel) && n < 20) begin
      cycle();
      n++;
    end
    check($sformatf("d%0d t6_halted", sel), 64'(obs_halted(sel)), 64'(1));
    sreq[sel] = 1'b1;
    cycle();
    sreq[sel] = 1'b0;
    wait_pos(sel, 2, 10);
    rst[sel] = 1'b1;
    cycle();
    check($sformatf("d%0d t6_rst_phase", sel), obs_phase(sel), 64'(0));
    check($sformatf("d%0d t6_rst_clk", sel), 64'(obs_clk(sel)), 64'(0));
    check($sformatf("d%0d t6_rst_state", sel), 64'((sel == 0) ? a_state : b_state), 64'(HOLD));
    rst[sel]  = 1'b0;
    hreq[sel] = 1'b0;
    n = 0;
    while (!obs_clk(sel) && n < 10) begin
      cycle();
      n++;
    end
    check($sformatf("d%0d t6_resume_lat", sel), 64'(n), 64'(2));
  endtask

  initial begin
    int n;
    int pulses[4];
    logic [3:0] en_seen;
    int halt_cnt, ones;

    m[0] = model_init(4, 4, A_PV, 4);
    m[1] = model_init(6, 2, 32'(B_PV), 32);
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; hreq[s] = 1'b0; sreq[s] = 1'b0; clr[s] = 1'b0;
    end
    repeat (2) cycle();
    check("rst_state", 64'(a_state), 64'(HOLD));
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Free run: first period begins after the settle cycles
    cycle();
    cycle();
    check("t1_first_en", 64'(a_en), 64'(1));
    check("t1_first_clk", 64'(a_clk_out), 64'(1));
    repeat (12) cycle();

    // Halt requested at phase 1
    wait_pos(0, 1, 8);
    hreq[0] = 1'b1;
    n = 0;
    while (!a_halted && n < 20) begin
      cycle();
      n++;
    end
    check("t2_halt_lat", 64'(n), 64'(3));
    en_seen = '0;
    repeat (10) begin
      cycle();
      en_seen = en_seen | a_en;
    end
    check("t2_quiet_en", 64'(en_seen), 64'(0));

    // Single step
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    sreq[0] = 1'b1;
    cycle();
    sreq[0] = 1'b0;
    for (int i = 0; i < 4; i++) pulses[i] += int'(a_en[i]);
    n = 0;
    while (!a_step_done && n < 20) begin
      cycle();
      n++;
      for (int i = 0; i < 4; i++) pulses[i] += int'(a_en[i]);
    end
    check("t3_step_lat", 64'(n), 64'(4));
    for (int i = 0; i < 4; i++) check($sformatf("t3_pulses_ch%0d", i), 64'(pulses[i]), 64'(1));
    check("t3_halted_after", 64'(a_halted), 64'(1));
    cycle();

    // Cancelled halt
    hreq[0] = 1'b0;
    repeat (6) cycle();
    wait_pos(0, 0, 8);
    hreq[0] = 1'b1;
    wait_pos(0, 2, 8);
    hreq[0] = 1'b0;
    halt_cnt = 0;
    ones     = 0;
    repeat (12) begin
      cycle();
      halt_cnt += int'(a_halted);
      ones     += int'(a_clk_out);
    end
    check("t4_no_halt", 64'(halt_cnt), 64'(0));
    check("t4_clk_duty", 64'(ones), 64'(6));

    // Performance counter saturation and clear-at-wrap
    clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0;
    repeat (80) cycle();
`ifdef CLKSEQ_PERF_CNT_EN
    check("t5_saturate", 64'(a_cnt), 64'(15));
`else
    check("t5_saturate", 64'(a_cnt), 64'(0));
`endif
    wait_pos(0, 3, 8);
    clr[0] = 1'b1;
    cycle();
    clr[0] = 1'b0;
    check("t5_clr_wrap", 64'(a_cnt), 64'(0));

    // Reset during a step, both geometries
    reset_mid_step(0);
    reset_mid_step(1);

    // Randomised control traffic on both instances
    for (int k = 0; k < 600; k++) begin
      for (int s = 0; s < 2; s++) begin
        if ($urandom_range(0, 7) == 0) hreq[s] = ~hreq[s];
        sreq[s] = ($urandom_range(0, 4) == 0);
        clr[s]  = ($urandom_range(0, 50) == 0);
        rst[s]  = ($urandom_range(0, 200) == 0);
      end
      cycle();
    end
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0; hreq[s] = 1'b0; sreq[s] = 1'b0; clr[s] = 1'b0;
    end
    repeat (8) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
